wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-back port arbiter in front of the 32×32 register file's single write port (we/waddr/wdata). It merges two result sources: the in-order pipeline write-back, which has no backpressure and highest priority, and a late-result source (load unit / multiply-divide unit) with a valid/ready handshake, buffered in a small FIFO. It drives the register-file write port from a registered output. It also exports a per-register pending-write mask for the hazard unit and a starvation stall request for pipeline control.

## Interface
- DEPTH, 4: late-result FIFO entries; power of 2, ≥2.
- STARVE_LIMIT, 8: consecutive cycles a non-empty FIFO may lose to the pipeline before stall is requested; 1..255.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pipe_valid  in  1  pipeline write-back request this cycle.
- pipe_addr  in  5  destination register.
- pipe_data  in  32  write data.
- late_valid  in  1  late-result request.
- late_ready  out  1  FIFO can accept; handshake when late_valid && late_ready at a rising edge.
- late_addr  in  5  destination register.
- late_data  in  32  write data.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).
- busy_mask  out  32  bit r = a write to register r is still pending in the FIFO or the output register.
- wb_stall  out  1  registered request that pipeline control hold pipe_valid low.

## Operation
- FIFO: circular buffer, DEPTH entries of {addr, data}. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- late_ready = !rst && (count != DEPTH). It depends on state only, not on a same-cycle pop. A full FIFO deasserts late_ready even if it pops that cycle.
- Accepted late write with late_addr == 0: handshake completes, entry is discarded, count unchanged. A FIFO entry never has addr 0.
- Output register selection each edge, in priority order:
  1. pipe_valid && pipe_addr != 0: load pipe_addr/pipe_data, rf_we=1.
  2. Else if FIFO non-empty: pop head, load it, rf_we=1.
  3. Else rf_we=0; rf_waddr/rf_wdata hold their previous values.
- pipe_valid with pipe_addr 0 is dropped and counts as no pipe request, so the FIFO may pop.
- Simultaneous push and pop on the same edge: both occur, count unchanged. If the FIFO is empty, a push and pop never occur on the same edge, because a new entry is only poppable from the next edge.
- The FIFO preserves late-write order. Pipeline writes may overtake FIFO entries. WAW ordering between sources is enforced by the hazard unit using busy_mask, not by this block.
- busy_mask (combinational from state):
  - bit r = OR over valid FIFO entries of (addr == r), OR (rf_we && rf_waddr == r).
  - bit 0 always 0.
- Starvation counter (8 bits):
  - Increments on each edge where the FIFO is non-empty and the pipeline wins.
  - Clears to 0 on any FIFO pop, or when the FIFO is empty.
  - wb_stall is set at the edge where the counter reaches STARVE_LIMIT, and cleared at the edge of the next FIFO pop.
  - While wb_stall is high, pipe_valid is still honoured with priority; the block never drops a pipe write.
- Reset mid-operation: FIFO contents discarded, pointers/count/counter cleared, pending writes lost.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, wb_stall=0, late_ready=0 while rst high and 1 on the first cycle after.
- Pipeline latency: request sampled at edge E0 → rf_we high after E0 → register file written at E1.
- Late latency, empty FIFO, no pipe traffic: handshake at E0 → entry poppable at E1 → rf_we high after E1 → register file written at E2.
- busy_mask bit for a late write rises after the accepting edge. It falls after the edge following the pop, once rf_we drops or the address changes.
- Throughput: one register-file write per cycle.

## Test plan
- Reset, then pipe write (addr 5, 0xDEADBEEF) at E0 → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF after E0; rf_we=0 after E1.
- Late write (addr 9, 0x1234) into an idle block → busy_mask[9]=1 after E0; rf_we/addr 9 after E1; busy_mask[9]=0 after E2.
- Five back-to-back late writes with DEPTH=4 and pipe_valid held high → late_ready=0 after the 4th accept; 5th waits. Release pipe → entries appear on the port in order 1..4, then 5.
- Late writes (addr 0) and pipe writes (addr 0) → never enqueued, rf_we stays 0, busy_mask stays 0.
- FIFO holds one entry, pipe_valid high continuously → wb_stall=1 after the 8th losing edge. Drop pipe_valid → entry pops next edge, wb_stall=0, counter=0.
- FIFO full (4 entries), rst asserted for one cycle → count 0, busy_mask=0, rf_we=0, late_ready=0 during rst and 1 after.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter: priority pipeline write-back plus a FIFO-buffered late-result source
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        late_valid,
  output logic        late_ready,
  input  logic [4:0]  late_addr,
  input  logic [31:0] late_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_mask,
  output logic        wb_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  LIMIT    = 8'(STARVE_LIMIT);

  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic fifo_nonempty;
  logic pipe_win;
  logic push;
  logic pop;

  assign late_ready    = !rst && (count_q != FULL_CNT);
  assign fifo_nonempty = (count_q != '0);
  assign pipe_win      = pipe_valid && (pipe_addr != 5'd0);
  // Writes to r0 complete the handshake but are never stored.
  assign push          = late_valid && late_ready && (late_addr != 5'd0);
  assign pop           = !pipe_win && fifo_nonempty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    stall_d    = stall_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);

    if (pipe_win) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_addr;
      rf_wdata_d = pipe_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_addr_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end

    // Counter saturates so a very long pipeline burst cannot wrap it.
    if (pop || !fifo_nonempty) starve_d = 8'd0;
    else if (starve_q != 8'hFF) starve_d = starve_q + 8'd1;

    if (pop) stall_d = 1'b0;
    else if (starve_d == LIMIT) stall_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= late_addr;
      fifo_data_q[wr_ptr_q] <= late_data;
    end
  end

  // An entry at slot i is live when its distance from the head is below the count.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, AW'(AW'(i) - rd_ptr_q)} < count_q) busy_mask[fifo_addr_q[i]] = 1'b1;
    end
    if (rf_we_q) busy_mask[rf_waddr_q] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_stall = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_addr;
  logic [31:0] late_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        wb_stall;

  int n_pass = 0;
  int n_total = 0;

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .late_valid(late_valid), .late_ready(late_ready),
    .late_addr(late_addr), .late_data(late_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
    late_valid = 1'b0; late_addr = '0; late_data = '0;
    tick(); tick();
    n_total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %0b want 0", rf_we); else n_pass++;
    n_total++; if (rf_waddr !== 5'd0) $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); else n_pass++;
    n_total++; if (rf_wdata !== 32'd0) $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); else n_pass++;
    n_total++; if (busy_mask !== 32'd0) $display("FAIL reset_busy got %h want 0", busy_mask); else n_pass++;
    n_total++; if (wb_stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", wb_stall); else n_pass++;
    n_total++; if (late_ready !== 1'b0) $display("FAIL reset_late_ready got %0b want 0", late_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (late_ready !== 1'b1) $display("FAIL post_reset_late_ready got %0b want 1", late_ready); else n_pass++;
  endtask

  task automatic test_pipe_write();
    pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    pipe_valid = 1'b0;
    n_total++; if (rf_we !== 1'b1) $display("FAIL pipe_we got %0b want 1", rf_we); else n_pass++;
    n_total++; if (rf_waddr !== 5'd5) $display("FAIL pipe_waddr got %0d want 5", rf_waddr); else n_pass++;
    n_total++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL pipe_wdata got %h want deadbeef", rf_wdata); else n_pass++;
    n_total++; if (busy_mask !== 32'h0000_0020) $display("FAIL pipe_busy got %h want 00000020", busy_mask); else n_pass++;
    tick();
    n_total++; if (rf_we !== 1'b0) $display("FAIL pipe_we_drop got %0b want 0", rf_we); else n_pass++;
    n_total++; if (rf_waddr !== 5'd5) $display("FAIL pipe_waddr_hold got %0d want 5", rf_waddr); else n_pass++;
    n_total++; if (busy_mask !== 32'd0) $display("FAIL pipe_busy_clear got %h want 0", busy_mask); else n_pass++;
  endtask

  task automatic test_late_write();
    late_valid = 1'b1; late_addr = 5'd9; late_data = 32'h1234;
    tick();
    late_valid = 1'b0;
    n_total++; if (busy_mask !== 32'h0000_0200) $display("FAIL late_busy_e0 got %h want 00000200", busy_mask); else n_pass++;
    n_total++; if (rf_we !== 1'b0) $display("FAIL late_we_e0 got %0b want 0", rf_we); else n_pass++;
    tick();
    n_total++; if (rf_we !== 1'b1) $display("FAIL late_we_e1 got %0b want 1", rf_we); else n_pass++;
    n_total++; if (rf_waddr !== 5'd9) $display("FAIL late_waddr_e1 got %0d want 9", rf_waddr); else n_pass++;
    n_total++; if (rf_wdata !== 32'h1234) $display("FAIL late_wdata_e1 got %h want 1234", rf_wdata); else n_pass++;
    n_total++; if (busy_mask !== 32'h0000_0200) $display("FAIL late_busy_e1 got %h want 00000200", busy_mask); else n_pass++;
    tick();
    n_total++; if (busy_mask !== 32'd0) $display("FAIL late_busy_e2 got %h want 0", busy_mask); else n_pass++;
    n_total++; if (rf_we !== 1'b0) $display("FAIL late_we_e2 got %0b want 0", rf_we); else n_pass++;
  endtask

  task automatic test_back_to_back();
    pipe_valid = 1'b1; pipe_addr = 5'd3; pipe_data = 32'hAAAA0000;
    for (int i = 1; i <= 4; i++) begin
      late_valid = 1'b1; late_addr = 5'(i); late_data = 32'(100 + i);
      tick();
    end
    n_total++; if (late_ready !== 1'b0) $display("FAIL b2b_full_ready got %0b want 0", late_ready); else n_pass++;
    n_total++; if (busy_mask !== 32'h0000_001E) $display("FAIL b2b_full_busy got %h want 0000001e", busy_mask); else n_pass++;
    late_addr = 5'd5; late_data = 32'd105;
    tick();
    n_total++; if (busy_mask[5] !== 1'b0) $display("FAIL b2b_fifth_waits got %0b want 0", busy_mask[5]); else n_pass++;
    n_total++; if (wb_stall !== 1'b0) $display("FAIL b2b_no_stall got %0b want 0", wb_stall); else n_pass++;
    pipe_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) late_valid = 1'b0;
      n_total++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'(100 + k))
        $display("FAIL b2b_order_%0d got we=%0b addr=%0d data=%0d want we=1 addr=%0d data=%0d",
                 k, rf_we, rf_waddr, rf_wdata, k, 100 + k);
      else n_pass++;
    end
    tick();
    n_total++; if (rf_we !== 1'b0) $display("FAIL b2b_drain_we got %0b want 0", rf_we); else n_pass++;
    n_total++; if (busy_mask !== 32'd0) $display("FAIL b2b_drain_busy got %h want 0", busy_mask); else n_pass++;
  endtask

  task automatic test_addr_zero();
    late_valid = 1'b1; late_addr = 5'd0; late_data = 32'h5555;
    pipe_valid = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h6666;
    n_total++; if (late_ready !== 1'b1) $display("FAIL zero_ready got %0b want 1", late_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (rf_we !== 1'b0 || busy_mask !== 32'd0)
        $display("FAIL zero_drop_%0d got we=%0b busy=%h want we=0 busy=0", i, rf_we, busy_mask);
      else n_pass++;
    end
    n_total++; if (rf_waddr !== 5'd5) $display("FAIL zero_waddr_hold got %0d want 5", rf_waddr); else n_pass++;
    late_valid = 1'b0; pipe_valid = 1'b0;
    tick();
    n_total++; if (rf_we !== 1'b0) $display("FAIL zero_no_pop got %0b want 0", rf_we); else n_pass++;
  endtask

  task automatic test_starvation();
    pipe_valid = 1'b1; pipe_addr = 5'd7; pipe_data = 32'h7777;
    late_valid = 1'b1; late_addr = 5'd12; late_data = 32'hC0C0;
    tick();
    late_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_total++; if (wb_stall !== 1'b0) $display("FAIL starve_early_%0d got %0b want 0", i, wb_stall); else n_pass++;
    end
    tick();
    n_total++; if (wb_stall !== 1'b1) $display("FAIL starve_set got %0b want 1", wb_stall); else n_pass++;
    tick();
    n_total++;
    if (wb_stall !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd7)
      $display("FAIL starve_pipe_honoured got stall=%0b we=%0b addr=%0d want 1 1 7", wb_stall, rf_we, rf_waddr);
    else n_pass++;
    n_total++; if (busy_mask !== 32'h0000_1080) $display("FAIL starve_busy got %h want 00001080", busy_mask); else n_pass++;
    pipe_valid = 1'b0;
    tick();
    n_total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0C0)
      $display("FAIL starve_pop got we=%0b addr=%0d data=%h want 1 12 c0c0", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    n_total++; if (wb_stall !== 1'b0) $display("FAIL starve_clear got %0b want 0", wb_stall); else n_pass++;
    // A fresh entry must again survive 8 losing edges before stall returns.
    pipe_valid = 1'b1;
    late_valid = 1'b1; late_addr = 5'd13; late_data = 32'hD0D0;
    tick();
    late_valid = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    n_total++; if (wb_stall !== 1'b0) $display("FAIL starve_restart_early got %0b want 0", wb_stall); else n_pass++;
    tick();
    n_total++; if (wb_stall !== 1'b1) $display("FAIL starve_restart_set got %0b want 1", wb_stall); else n_pass++;
    pipe_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    pipe_valid = 1'b1; pipe_addr = 5'd2; pipe_data = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      late_valid = 1'b1; late_addr = 5'(20 + i); late_data = 32'(i);
      tick();
    end
    late_valid = 1'b0;
    n_total++; if (late_ready !== 1'b0) $display("FAIL rstmid_full got %0b want 0", late_ready); else n_pass++;
    n_total++; if (busy_mask !== 32'h00F0_0004) $display("FAIL rstmid_busy_before got %h want 00f00004", busy_mask); else n_pass++;
    rst = 1'b1; pipe_valid = 1'b0;
    #1;
    n_total++; if (late_ready !== 1'b0) $display("FAIL rstmid_ready_in_rst got %0b want 0", late_ready); else n_pass++;
    tick();
    n_total++; if (busy_mask !== 32'd0) $display("FAIL rstmid_busy got %h want 0", busy_mask); else n_pass++;
    n_total++; if (rf_we !== 1'b0) $display("FAIL rstmid_we got %0b want 0", rf_we); else n_pass++;
    n_total++; if (wb_stall !== 1'b0) $display("FAIL rstmid_stall got %0b want 0", wb_stall); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (late_ready !== 1'b1) $display("FAIL rstmid_ready_after got %0b want 1", late_ready); else n_pass++;
    tick();
    n_total++;
    if (rf_we !== 1'b0 || busy_mask !== 32'd0)
      $display("FAIL rstmid_empty got we=%0b busy=%h want 0 0", rf_we, busy_mask);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_late_write();
    test_back_to_back();
    test_addr_zero();
    test_starvation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
